multi_pulse_gen: RTL and testbench

//  Multi-channel periodic pulse generator; parametrised successor of the single-channel delayed pulse block.

---
 rtl/multi_pulse_gen.sv | 190 +++++++++++++++++++
 tb/tb_multi_pulse_gen.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/multi_pulse_gen.sv
// multi_pulse_gen: multi-channel periodic pulse generator.
// One shared period counter drives N_CH active-low trigger lines; channel i
// pulses WIDTH_T cycles long at offset i*PHASE_T inside every period.
// Supports continuous run, graceful stop at period end and a channel mask that
// is sampled only at period start.
// Optional feature macro: PULSE_BURST_EN (counted burst mode with start/done).
module multi_pulse_gen #(
    parameter int unsigned CLK_MHZ   = 24,
    parameter int unsigned N_CH      = 4,
    parameter int unsigned PERIOD_US = 25_000,
    parameter int unsigned WIDTH_US  = 50,
    parameter int unsigned PHASE_US  = 1_000
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    input  logic            run_en,
    input  logic            start,
    input  logic [7:0]      burst_len,
    input  logic [N_CH-1:0] ch_disable,
    output logic [N_CH-1:0] pulse_out,
    output logic            busy,
    output logic            period_tick,
    output logic            done
);

    localparam int unsigned PERIOD_T = CLK_MHZ * PERIOD_US;
    localparam int unsigned WIDTH_T  = CLK_MHZ * WIDTH_US;
    localparam int unsigned PHASE_T  = CLK_MHZ * PHASE_US;
    localparam int unsigned LAST_END = (N_CH - 1) * PHASE_T + WIDTH_T;
    localparam int unsigned CNT_W    = (PERIOD_T > 1) ? $clog2(PERIOD_T) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD_T - 1);

    // Reject configurations where a pulse would be empty or spill past the period.
    if (N_CH < 1 || N_CH > 16) begin : g_bad_nch
        $error("multi_pulse_gen: N_CH must be in 1..16");
    end
    if (WIDTH_T < 1 || LAST_END > PERIOD_T) begin : g_bad_timing
        $error("multi_pulse_gen: need WIDTH_T >= 1 and last channel window inside period");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOP
`ifdef PULSE_BURST_EN
        , BURST
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_CH-1:0]   mask_q, mask_d;
    // One-cycle delayed copy of the counter, so the mask latched at cnt==0
    // is already valid when the first pulse of the period is decided.
    logic              run_p_q, run_p_d;
    logic [CNT_W-1:0]  cnt_p_q, cnt_p_d;
    logic [N_CH-1:0]   pulse_out_q, pulse_out_d;
    logic              tick_q, tick_d;
    logic [N_CH-1:0]   in_win;
    logic              running;
    logic              wrap;

`ifdef PULSE_BURST_EN
    logic [7:0]        rem_q, rem_d;
    logic              done_q, done_d;
`else
    logic              unused_burst_in;
    assign unused_burst_in = start ^ (^burst_len);
`endif

    assign running = (state_q != IDLE);
    assign wrap    = (cnt_q == CNT_LAST);

    // Per-channel window decode on the delayed counter value.
    for (genvar i = 0; i < N_CH; i++) begin : g_win
        localparam int unsigned LO = i * PHASE_T;
        localparam int unsigned HI = LO + WIDTH_T;
        if (LO == 0) begin : g_first
            assign in_win[i] = ({1'b0, cnt_p_q} < (CNT_W+1)'(HI));
        end else begin : g_rest
            assign in_win[i] = ({1'b0, cnt_p_q} >= (CNT_W+1)'(LO)) &&
                               ({1'b0, cnt_p_q} <  (CNT_W+1)'(HI));
        end
    end

    // Next-state, period counter, mask latch and burst bookkeeping.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
`ifdef PULSE_BURST_EN
        rem_d   = rem_q;
        done_d  = 1'b0;
`endif
        if (running) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
            if (cnt_q == '0) begin
                mask_d = ch_disable;
            end
        end

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (run_en) begin
                    state_d = RUN;
                end
`ifdef PULSE_BURST_EN
                else if (start && burst_len != 8'd0) begin
                    state_d = BURST;
                    rem_d   = burst_len;
                end
`endif
            end
            RUN: begin
                if (!run_en) state_d = STOP;
            end
            STOP: begin
                if (run_en)    state_d = RUN;
                else if (wrap) state_d = IDLE;
            end
`ifdef PULSE_BURST_EN
            BURST: begin
                if (wrap) begin
                    if (rem_q == 8'd1) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        rem_d = rem_q - 8'd1;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Output stage: pulses and period tick derived from the delayed counter.
    always_comb begin
        run_p_d = running;
        cnt_p_d = cnt_q;
        tick_d  = run_p_q && (cnt_p_q == '0);
        pulse_out_d = ~({N_CH{run_p_q}} & ~mask_q & in_win);
    end

    // State and pipeline registers with synchronous reset.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mask_q      <= '0;
            run_p_q     <= 1'b0;
            cnt_p_q     <= '0;
            pulse_out_q <= '1;
            tick_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values together.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mask_q      <= mask_d;
            run_p_q     <= run_p_d;
            cnt_p_q     <= cnt_p_d;
            pulse_out_q <= pulse_out_d;
            tick_q      <= tick_d;
        end
    end

`ifdef PULSE_BURST_EN
    // Burst remaining-period counter and completion strobe.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rem_q  <= '0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            done_q <= done_d;
        end
    end
    assign done = done_q;
`else
    assign done = 1'b0;
`endif

    assign pulse_out   = pulse_out_q;
    assign period_tick = tick_q;
    assign busy        = running;

endmodule

// File: tb/tb_multi_pulse_gen.sv
// tb_multi_pulse_gen: directed bench for multi_pulse_gen
// (CLK_MHZ=1, N_CH=4, PERIOD_US=20, WIDTH_US=3, PHASE_US=5).
// Cycle c means the interval after the c-th rising edge, counted from the edge
// that first samples run_en=1 (or start). Inputs change and outputs are
// checked on the falling edge.
module tb_multi_pulse_gen;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       run_en;
    logic       start;
    logic [7:0] burst_len;
    logic [3:0] ch_disable;
    logic [3:0] pulse_out;
    logic       busy;
    logic       period_tick;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;

    multi_pulse_gen #(
        .CLK_MHZ  (1),
        .N_CH     (4),
        .PERIOD_US(20),
        .WIDTH_US (3),
        .PHASE_US (5)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .run_en     (run_en),
        .start      (start),
        .burst_len  (burst_len),
        .ch_disable (ch_disable),
        .pulse_out  (pulse_out),
        .busy       (busy),
        .period_tick(period_tick),
        .done       (done)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    task automatic do_reset();
        sys_rst    = 1'b1;
        run_en     = 1'b0;
        start      = 1'b0;
        burst_len  = 8'd0;
        ch_disable = 4'b0000;
        repeat (3) step();
        sys_rst = 1'b0;
        step();
    endtask

    // Expected pulse lines at cycle c: ch i low for phase 5i..5i+2 of each
    // 20-cycle period starting at cycle 2; ch2 silent in period masked_p;
    // nothing after last_c.
    function automatic logic [3:0] exp_pulse(int c, int masked_p, int last_c);
        logic [3:0] r;
        int ph;
        int p;
        r = 4'hF;
        if (c >= 2 && c <= last_c) begin
            ph = (c - 2) % 20;
            p  = (c - 2) / 20;
            for (int i = 0; i < 4; i++) begin
                if (ph >= 5 * i && ph < 5 * i + 3 && !(i == 2 && p == masked_p)) r[i] = 1'b0;
            end
        end
        return r;
    endfunction

    function automatic logic exp_tick(int c, int last_c);
        return (c >= 2 && c <= last_c && ((c - 2) % 20) == 0);
    endfunction

    initial begin
        // Reset state
        do_reset();
        check("rst pulse_out", 32'(pulse_out), 32'hF);
        check("rst busy", 32'(busy), 32'd0);
        check("rst period_tick", 32'(period_tick), 32'd0);
        check("rst done", 32'(done), 32'd0);

        // Continuous run with mid-period ch2 disable/enable
        run_en = 1'b1;
        for (int c = 0; c <= 79; c++) begin
            step();
            check($sformatf("cont pulse c=%0d", c), 32'(pulse_out), 32'(exp_pulse(c, 2, 1000)));
            check($sformatf("cont tick c=%0d", c), 32'(period_tick), 32'(exp_tick(c, 1000)));
            check($sformatf("cont busy c=%0d", c), 32'(busy), 32'd1);
            if (c == 25) ch_disable = 4'b0100;
            if (c == 45) ch_disable = 4'b0000;
        end

        // Graceful stop: run_en drops at 30, current period completes
        do_reset();
        run_en = 1'b1;
        for (int c = 0; c <= 60; c++) begin
            step();
            check($sformatf("stop pulse c=%0d", c), 32'(pulse_out), 32'(exp_pulse(c, -1, 41)));
            check($sformatf("stop tick c=%0d", c), 32'(period_tick), 32'(exp_tick(c, 41)));
            check($sformatf("stop busy c=%0d", c), 32'(busy), 32'(c < 40));
            if (c == 30) run_en = 1'b0;
        end

        // Stop then resume inside the same period: no gap
        do_reset();
        run_en = 1'b1;
        for (int c = 0; c <= 65; c++) begin
            step();
            check($sformatf("resume pulse c=%0d", c), 32'(pulse_out), 32'(exp_pulse(c, -1, 1000)));
            check($sformatf("resume busy c=%0d", c), 32'(busy), 32'd1);
            if (c == 30) run_en = 1'b0;
            if (c == 35) run_en = 1'b1;
        end

        // Reset while ch2 is low
        do_reset();
        run_en = 1'b1;
        for (int c = 0; c <= 12; c++) step();
        check("midrst before pulse_out", 32'(pulse_out), 32'hB);
        sys_rst = 1'b1;
        step();
        check("midrst pulse_out", 32'(pulse_out), 32'hF);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst tick", 32'(period_tick), 32'd0);

`ifdef PULSE_BURST_EN
        // Burst of 3 periods
        do_reset();
        start     = 1'b1;
        burst_len = 8'd3;
        for (int c = 0; c <= 70; c++) begin
            step();
            start = 1'b0;
            check($sformatf("burst pulse c=%0d", c), 32'(pulse_out), 32'(exp_pulse(c, -1, 61)));
            check($sformatf("burst tick c=%0d", c), 32'(period_tick), 32'(exp_tick(c, 61)));
            check($sformatf("burst busy c=%0d", c), 32'(busy), 32'(c < 60));
            check($sformatf("burst done c=%0d", c), 32'(done), 32'(c == 60));
        end

        // burst_len of zero is ignored
        start     = 1'b1;
        burst_len = 8'd0;
        for (int c = 0; c <= 5; c++) begin
            step();
            start = 1'b0;
            check($sformatf("burst0 busy c=%0d", c), 32'(busy), 32'd0);
            check($sformatf("burst0 pulse c=%0d", c), 32'(pulse_out), 32'hF);
        end
`else
        // Burst disabled: start has no effect, done stays low
        do_reset();
        start     = 1'b1;
        burst_len = 8'd3;
        for (int c = 0; c <= 25; c++) begin
            step();
            start = 1'b0;
            check($sformatf("noburst busy c=%0d", c), 32'(busy), 32'd0);
            check($sformatf("noburst done c=%0d", c), 32'(done), 32'd0);
            check($sformatf("noburst pulse c=%0d", c), 32'(pulse_out), 32'hF);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
